mp_add_seq: RTL and testbench

//   Multi-precision add/subtract sequencer around the shared 16-bit ripple adder (adder16).

---
 rtl/mp_add_seq_pkg.sv | 15 +
 rtl/adder16.sv | 12 +
 rtl/mp_add_seq.sv | 116 +++++++++++
 tb/tb_mp_add_seq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package mp_add_seq_pkg;

  localparam int unsigned SLICE_W = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/adder16.sv
// 16-bit ripple adder shared by the arithmetic unit.
module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  assign {cout, s} = 17'(a) + 17'(b) + 17'(cin);

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: streams WORDS 16-bit slices, LSW first, through one adder16.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op,
  input  logic [SLICE_W*WORDS-1:0] a_in,
  input  logic [SLICE_W*WORDS-1:0] b_in,
  output logic                     busy,
  output logic                     done,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero
);

  state_e                           state_q, state_d;
  logic [WORDS-1:0][SLICE_W-1:0]    a_q, b_q;
  logic [WORDS-1:0][SLICE_W-1:0]    result_q, result_d;
  logic                             op_q;
  logic [CNT_W-1:0]                 idx_q, idx_d;
  logic                             carry_q;
  logic                             cout_q, ovf_q, zero_q;

  logic [SLICE_W-1:0]               slice_a, slice_b, slice_s;
  logic                             slice_cout;
  logic                             accept, running, last_slice;

  assign accept     = (state_q == StIdle) && start;
  assign running    = (state_q == StRun);
  assign last_slice = (idx_q == CNT_W'(WORDS - 1));

  // Subtraction is A + ~B + 1; the +1 comes from the carry seeded with op.
  assign slice_a = a_q[idx_q];
  assign slice_b = b_q[idx_q] ^ {SLICE_W{op_q == OP_SUB}};

  adder16 u_adder16 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        result_d[idx_q] = slice_s;
        if (last_slice) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      if (accept) begin
        a_q     <= a_in;
        b_q     <= b_in;
        op_q    <= op;
        carry_q <= op;
      end else if (running) begin
        carry_q <= slice_cout;
      end
      // Flags are taken from the top slice so they are valid in the done cycle.
      if (running && last_slice) begin
        cout_q <= slice_cout;
        ovf_q  <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                  (slice_s[SLICE_W-1] != slice_a[SLICE_W-1]);
        zero_q <= (result_d == '0);
      end
    end
  end

  assign busy   = (state_q == StRun) || (state_q == StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq (WORDS=4).
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [63:0] a_in, b_in;
  logic        busy, done, cout, ovf, zero;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mp_add_seq #(
    .WORDS (4),
    .CNT_W (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge while idle; returns #1 after the idle cycle following done.
  task automatic run_op(input string tag, input logic op_v, input logic [63:0] a_v,
                        input logic [63:0] b_v, input logic [63:0] exp_r, input logic exp_c,
                        input logic exp_o, input logic exp_z, input bit disturb);
    int cyc;
    start = 1'b1;
    op    = op_v;
    a_in  = a_v;
    b_in  = b_v;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = ~op_v;
    a_in  = ~a_v;
    b_in  = 64'h0123_4567_89AB_CDEF;
    // cyc 1 is the first cycle after the accepting edge; done is due in cyc 5.
    cyc = 1;
    while (!done && cyc < 20) begin
      start = disturb && (cyc == 2);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 64'(cyc), 64'd5);
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_result"}, result, exp_r);
    check_eq({tag, "_cout"}, 64'(cout), 64'(exp_c));
    check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
    check_eq({tag, "_zero"}, 64'(zero), 64'(exp_z));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_width"}, 64'(done), 64'd0);
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    check_eq({tag, "_held"}, result, exp_r);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_carry16", 1'b0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_0003,
           64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_5m7", 1'b1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_7m5", 1'b1, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0005,
           64'h0000_0000_0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the second RUN cycle: everything clears at once, no done follows.
    start = 1'b1;
    op    = 1'b0;
    a_in  = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in  = 64'h0000_0000_0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_result", result, 64'd0);
    check_eq("midrst_cout", 64'(cout), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) rst_n = 1'b1;
      if (done) seen++;
    end
    check_eq("midrst_no_done", 64'(seen), 64'd0);
    check_eq("midrst_idle", 64'(busy), 64'd0);

    run_op("add_sovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_sovf", 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("add_ignore_start", 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
           64'h0000_0000_0000_0003, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("add_mixed", 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
           64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_equal", 1'b1, 64'hABCD_0000_1234_FFFF, 64'hABCD_0000_1234_FFFF,
           64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_0m1", 1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_0mmin", 1'b1, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
